// File: rtl/line_buf_sched_if.sv
// Signal bundle between the PPU/VGA timing side (master) and the line-buffer scheduler (slave).
// Counter outputs exist only when LINE_BUF_STATS_EN is defined.
interface line_buf_sched_if #(
    parameter int ADDR_W = 9
);
    logic              frame_sync;
    logic              ppu_line_start;
    logic              ppu_pix_valid;
    logic              vga_line_start;
    logic              vga_vactive;
    logic [9:0]        h_cnt;
    logic              flag_clr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en0;
    logic              wr_en1;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bank;
    logic              rd_pix_en;
    logic              overrun;
    logic              underrun;
`ifdef LINE_BUF_STATS_EN
    logic [7:0]        ovr_cnt;
    logic [7:0]        udr_cnt;
`endif

    modport master (
        output frame_sync, ppu_line_start, ppu_pix_valid,
        output vga_line_start, vga_vactive, h_cnt, flag_clr,
`ifdef LINE_BUF_STATS_EN
        input  ovr_cnt, udr_cnt,
`endif
        input  wr_addr, wr_en0, wr_en1, rd_addr, rd_bank, rd_pix_en,
        input  overrun, underrun
    );

    modport slave (
        input  frame_sync, ppu_line_start, ppu_pix_valid,
        input  vga_line_start, vga_vactive, h_cnt, flag_clr,
`ifdef LINE_BUF_STATS_EN
        output ovr_cnt, udr_cnt,
`endif
        output wr_addr, wr_en0, wr_en1, rd_addr, rd_bank, rd_pix_en,
        output overrun, underrun
    );
endinterface

// File: rtl/line_buf_sched.sv
// Ping-pong line-buffer scheduler: PPU fills one bank while VGA scan-doubles the other.
// Define LINE_BUF_STATS_EN to add saturating overrun/underrun event counters.
//
// state   | meaning
// W_IDLE  | writer waiting for ppu_line_start
// W_FILL  | writer storing pixels into wr_bank
// W_DROP  | writer discarding a line (target bank still full)
// R_IDLE  | reader outside vertical active area
// R_SHOW  | reader scanning out full bank rd_bank_int
// R_BLANK | reader showing border (no full bank at line start)
module line_buf_sched #(
    parameter int SRC_PIXELS = 256,
    parameter int ADDR_W     = 9,
    parameter int H_OFFSET   = 64,
    parameter int REPEAT     = 2
) (
    input logic             pclk,
    input logic             rst,
    line_buf_sched_if.slave bus
);
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SHOW, R_BLANK} r_state_t;

    localparam logic [9:0]        WIN_LO    = 10'(H_OFFSET);
    localparam logic [9:0]        WIN_LAST  = 10'(H_OFFSET + 2 * SRC_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SRC_PIXELS - 1);
    localparam logic [1:0]        REP_LAST  = 2'(REPEAT - 1);

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [1:0]        full, full_set, full_clr;
    logic              wr_bank, wr_bank_next;
    logic              rd_bank_int, rd_bank_next;
    logic [1:0]        rep_cnt, rep_next;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_next;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [9:0]        h_rel;
    logic              in_win, show_pix;
    logic [1:0]        pix_pipe, bank_pipe;
    logic              ovr_evt, udr_evt;
    logic              overrun_q, underrun_q;

    assign h_rel    = bus.h_cnt - WIN_LO;
    assign in_win   = (bus.h_cnt >= WIN_LO) && (bus.h_cnt <= WIN_LAST);
    assign show_pix = (r_state == R_SHOW) && in_win;

    // Writer: next state, address, bank set strobe
    always_comb begin
        w_next       = w_state;
        wr_addr_next = wr_addr_q;
        wr_bank_next = wr_bank;
        full_set     = 2'b00;
        ovr_evt      = 1'b0;
        if (bus.frame_sync) begin
            wr_bank_next = 1'b0;
            wr_addr_next = '0;
            w_next       = bus.ppu_line_start ? W_FILL : W_IDLE;
        end else begin
            case (w_state)
                W_FILL: begin
                    if (bus.ppu_line_start) begin
                        wr_addr_next = '0;
                    end else if (bus.ppu_pix_valid) begin
                        if (wr_addr_q == ADDR_LAST) begin
                            full_set[wr_bank] = 1'b1;
                            wr_bank_next      = ~wr_bank;
                            wr_addr_next      = '0;
                            w_next            = W_IDLE;
                        end else begin
                            wr_addr_next = wr_addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    if (bus.ppu_line_start) begin
                        if (full[wr_bank]) begin
                            w_next  = W_DROP;
                            ovr_evt = 1'b1;
                        end else begin
                            w_next       = W_FILL;
                            wr_addr_next = '0;
                        end
                    end
                end
            endcase
        end
    end

    // Reader: decisions only at line start; hand-over at last window pixel
    always_comb begin
        r_next       = r_state;
        rd_bank_next = rd_bank_int;
        rep_next     = rep_cnt;
        full_clr     = 2'b00;
        udr_evt      = 1'b0;
        if (bus.frame_sync) begin
            r_next       = R_IDLE;
            rd_bank_next = 1'b0;
            rep_next     = 2'd0;
        end else if (bus.vga_line_start) begin
            if (!bus.vga_vactive) begin
                r_next = R_IDLE;
            end else if (full[rd_bank_int]) begin
                r_next = R_SHOW;
            end else begin
                r_next  = R_BLANK;
                udr_evt = 1'b1;
            end
        end else if ((r_state == R_SHOW) && (bus.h_cnt == WIN_LAST)) begin
            if (rep_cnt == REP_LAST) begin
                full_clr[rd_bank_int] = 1'b1;
                rd_bank_next          = ~rd_bank_int;
                rep_next              = 2'd0;
            end else begin
                rep_next = rep_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank_int <= 1'b0;
            rep_cnt     <= 2'd0;
            wr_addr_q   <= '0;
        end else begin
            w_state     <= w_next;
            r_state     <= r_next;
            wr_bank     <= wr_bank_next;
            rd_bank_int <= rd_bank_next;
            rep_cnt     <= rep_next;
            wr_addr_q   <= wr_addr_next;
            // Set and clear never target the same bank, so both apply
            full        <= bus.frame_sync ? 2'b00 : ((full & ~full_clr) | full_set);
        end
    end

    // Read pipeline: address one cycle after h_cnt, RAM data one cycle later
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_addr_q <= '0;
            pix_pipe  <= 2'b00;
            bank_pipe <= 2'b00;
        end else begin
            if (show_pix) begin
                rd_addr_q <= ADDR_W'(h_rel >> 1);
            end
            pix_pipe  <= bus.frame_sync ? 2'b00 : {pix_pipe[0], show_pix};
            bank_pipe <= {bank_pipe[0], rd_bank_int};
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= (overrun_q & ~bus.flag_clr) | ovr_evt;
            underrun_q <= (underrun_q & ~bus.flag_clr) | udr_evt;
        end
    end

`ifdef LINE_BUF_STATS_EN
    logic [7:0] ovr_cnt_q, udr_cnt_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            ovr_cnt_q <= 8'd0;
            udr_cnt_q <= 8'd0;
        end else begin
            if (bus.flag_clr) begin
                ovr_cnt_q <= {7'd0, ovr_evt};
            end else if (ovr_evt && (ovr_cnt_q != 8'hFF)) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
            if (bus.flag_clr) begin
                udr_cnt_q <= {7'd0, udr_evt};
            end else if (udr_evt && (udr_cnt_q != 8'hFF)) begin
                udr_cnt_q <= udr_cnt_q + 8'd1;
            end
        end
    end

    assign bus.ovr_cnt = ovr_cnt_q;
    assign bus.udr_cnt = udr_cnt_q;
`endif

    assign bus.wr_en0    = (w_state == W_FILL) && bus.ppu_pix_valid && !wr_bank;
    assign bus.wr_en1    = (w_state == W_FILL) && bus.ppu_pix_valid && wr_bank;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_bank   = bank_pipe[1];
    assign bus.rd_pix_en = pix_pipe[1];
    assign bus.overrun   = overrun_q;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_line_buf_sched.sv
// Randomised and directed bench for line_buf_sched against a line-level behavioural model.
module tb_line_buf_sched;
    localparam int SRC      = 256;
    localparam int AW       = 9;
    localparam int HOFF     = 64;
    localparam int REP      = 2;
    localparam int LINE_LEN = 600;
    localparam int WIN_END  = HOFF + 2 * SRC;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    line_buf_sched_if #(.ADDR_W(AW)) bus ();

    line_buf_sched #(
        .SRC_PIXELS(SRC),
        .ADDR_W    (AW),
        .H_OFFSET  (HOFF),
        .REPEAT    (REP)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: banks are flags, writer is "filling or not", reader is "showing or not"
    bit [1:0] m_full = 2'b00;
    int       m_wb = 0, m_rb = 0, m_rep = 0, m_waddr = 0, m_rd_addr = 0;
    bit       m_filling = 1'b0, m_showing = 1'b0;
    bit       pq1 = 1'b0, pq2 = 1'b0;
    int       bq1 = 0, bq2 = 0;
    bit       m_ovr = 1'b0, m_udr = 1'b0;
    int       m_oc = 0, m_uc = 0;
    bit [1:0] setm, clrm;
    bit       oe, ue, mshow;
    int       mh;

    always @(posedge pclk) begin
        if (rst) begin
            m_full = 2'b00; m_wb = 0; m_rb = 0; m_rep = 0; m_waddr = 0; m_rd_addr = 0;
            m_filling = 1'b0; m_showing = 1'b0; pq1 = 1'b0; pq2 = 1'b0; bq1 = 0; bq2 = 0;
            m_ovr = 1'b0; m_udr = 1'b0; m_oc = 0; m_uc = 0;
        end else begin
            setm = 2'b00; clrm = 2'b00; oe = 1'b0; ue = 1'b0;
            mh = int'(bus.h_cnt);
            mshow = m_showing && (mh >= HOFF) && (mh < WIN_END);
            bq2 = bq1;
            bq1 = m_rb;
            if (mshow) m_rd_addr = (mh - HOFF) / 2;
            if (bus.frame_sync) begin
                m_full = 2'b00; m_wb = 0; m_rb = 0; m_rep = 0; m_showing = 1'b0;
                pq1 = 1'b0; pq2 = 1'b0;
                m_filling = bus.ppu_line_start;
                m_waddr = 0;
            end else begin
                pq2 = pq1;
                pq1 = mshow;
                if (bus.ppu_line_start) begin
                    if (m_filling || !m_full[m_wb]) begin
                        m_filling = 1'b1;
                        m_waddr = 0;
                    end else begin
                        oe = 1'b1;
                    end
                end else if (m_filling && bus.ppu_pix_valid) begin
                    if (m_waddr == SRC - 1) begin
                        setm[m_wb] = 1'b1;
                        m_wb = 1 - m_wb;
                        m_filling = 1'b0;
                        m_waddr = 0;
                    end else begin
                        m_waddr++;
                    end
                end
                if (bus.vga_line_start) begin
                    m_showing = bus.vga_vactive && m_full[m_rb];
                    ue = bus.vga_vactive && !m_full[m_rb];
                end else if (m_showing && mh == WIN_END - 1) begin
                    m_rep++;
                    if (m_rep == REP) begin
                        clrm[m_rb] = 1'b1;
                        m_rb = 1 - m_rb;
                        m_rep = 0;
                    end
                end
                m_full = (m_full & ~clrm) | setm;
            end
            m_ovr = (m_ovr && !bus.flag_clr) || oe;
            m_udr = (m_udr && !bus.flag_clr) || ue;
            if (bus.flag_clr) m_oc = int'(oe);
            else if (oe && m_oc < 255) m_oc++;
            if (bus.flag_clr) m_uc = int'(ue);
            else if (ue && m_uc < 255) m_uc++;
        end
    end

    // Compare process plus per-line observation counters for the directed checks
    int mon_we0 = 0, mon_we1 = 0, last_wa = -1;
    int ln_pix = 0, ln_first = -1, ln_last = -1, ln_b0 = 0, ln_b1 = 0;
    int ln_addr_a = -1, ln_addr_b = -1;

    always @(negedge pclk) begin
        if (chk_en) begin
            chk("wr_en0", int'(bus.wr_en0), int'(m_filling && bus.ppu_pix_valid && m_wb == 0));
            chk("wr_en1", int'(bus.wr_en1), int'(m_filling && bus.ppu_pix_valid && m_wb == 1));
            chk("wr_addr", int'(bus.wr_addr), m_waddr);
            chk("rd_addr", int'(bus.rd_addr), m_rd_addr);
            chk("rd_bank", int'(bus.rd_bank), bq2);
            chk("rd_pix_en", int'(bus.rd_pix_en), int'(pq2));
            chk("overrun", int'(bus.overrun), int'(m_ovr));
            chk("underrun", int'(bus.underrun), int'(m_udr));
`ifdef LINE_BUF_STATS_EN
            chk("ovr_cnt", int'(bus.ovr_cnt), m_oc);
            chk("udr_cnt", int'(bus.udr_cnt), m_uc);
`endif
        end
        if (bus.wr_en0) mon_we0++;
        if (bus.wr_en1) mon_we1++;
        if (bus.wr_en0 || bus.wr_en1) last_wa = int'(bus.wr_addr);
        if (bus.vga_line_start) begin
            ln_pix = 0; ln_first = -1; ln_last = -1; ln_b0 = 0; ln_b1 = 0;
        end
        if (bus.rd_pix_en) begin
            ln_pix++;
            if (ln_first < 0) ln_first = int'(bus.h_cnt);
            ln_last = int'(bus.h_cnt);
            if (bus.rd_bank) ln_b1++;
            else ln_b0++;
        end
        if (bus.h_cnt == 10'd66) ln_addr_a = int'(bus.rd_addr);
        if (bus.h_cnt == 10'd576) ln_addr_b = int'(bus.rd_addr);
    end

    task automatic tick();
        @(posedge pclk);
        #2;
        bus.frame_sync     = 1'b0;
        bus.ppu_line_start = 1'b0;
        bus.vga_line_start = 1'b0;
        bus.flag_clr       = 1'b0;
    endtask

    task automatic ppu_line(input int n);
        bus.ppu_line_start = 1'b1;
        bus.ppu_pix_valid  = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            bus.ppu_pix_valid = 1'b1;
            tick();
        end
        bus.ppu_pix_valid = 1'b0;
    endtask

    task automatic vga_line(input bit active);
        for (int h = 0; h < LINE_LEN; h++) begin
            bus.h_cnt          = 10'(h);
            bus.vga_line_start = (h == 0);
            bus.vga_vactive    = active;
            tick();
        end
    endtask

    int b0, b1, h, rem, gap;
    bit act;

    initial begin
        bus.frame_sync = 1'b0; bus.ppu_line_start = 1'b0; bus.ppu_pix_valid = 1'b0;
        bus.vga_line_start = 1'b0; bus.vga_vactive = 1'b0; bus.h_cnt = 10'd0; bus.flag_clr = 1'b0;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_pix_en", int'(bus.rd_pix_en), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        rst = 1'b0;
        tick();

        // Fill bank 0, then bank 1
        b0 = mon_we0; b1 = mon_we1;
        ppu_line(SRC);
        chk("fill0_we0", mon_we0 - b0, 256);
        chk("fill0_we1", mon_we1 - b1, 0);
        chk("fill0_last_addr", last_wa, 255);
        chk("pin_full_after_fill0", int'(m_full), 1);
        b0 = mon_we0; b1 = mon_we1;
        ppu_line(SRC);
        chk("fill1_we1", mon_we1 - b1, 256);
        chk("fill1_we0", mon_we0 - b0, 0);
        chk("pin_full_both", int'(m_full), 3);

        // Third line with both banks full is dropped
        chk("ovr_before", int'(bus.overrun), 0);
        b0 = mon_we0; b1 = mon_we1;
        ppu_line(SRC);
        chk("ovr_no_writes", (mon_we0 - b0) + (mon_we1 - b1), 0);
        chk("ovr_flag", int'(bus.overrun), 1);

        // Scan-doubled readout and hand-over
        vga_line(1'b1);
        chk("l1_first_h", ln_first, 66);
        chk("l1_last_h", ln_last, 577);
        chk("l1_pix", ln_pix, 512);
        chk("l1_addr_start", ln_addr_a, 0);
        chk("l1_addr_end", ln_addr_b, 255);
        chk("l1_bank1_pix", ln_b1, 0);
        vga_line(1'b1);
        chk("l2_bank0_pix", ln_b0, 512);
        chk("pin_full_after_l2", int'(m_full), 2);
        vga_line(1'b1);
        chk("l3_bank1_pix", ln_b1, 512);
        chk("l3_bank0_pix", ln_b0, 0);
        vga_line(1'b1);
        chk("udr_before", int'(bus.underrun), 0);
        vga_line(1'b1);
        chk("l5_pix", ln_pix, 0);
        chk("udr_flag", int'(bus.underrun), 1);
        bus.flag_clr = 1'b1;
        tick();
        chk("clr_overrun", int'(bus.overrun), 0);
        chk("clr_underrun", int'(bus.underrun), 0);

        // frame_sync in the middle of a fill
        ppu_line(SRC);
        ppu_line(100);
        chk("fs_mid_addr", int'(bus.wr_addr), 100);
        bus.frame_sync = 1'b1;
        tick();
        chk("fs_wr_addr", int'(bus.wr_addr), 0);
        b0 = mon_we0; b1 = mon_we1;
        for (int i = 0; i < 50; i++) begin
            bus.ppu_pix_valid = 1'b1;
            tick();
        end
        bus.ppu_pix_valid = 1'b0;
        chk("fs_writes_stop", (mon_we0 - b0) + (mon_we1 - b1), 0);
        vga_line(1'b1);
        chk("fs_banks_empty_pix", ln_pix, 0);
        b0 = mon_we0;
        ppu_line(SRC);
        chk("fs_refill_bank0", mon_we0 - b0, 256);

        // Randomised traffic
        h = 0; rem = 0; act = 1'b1;
        for (int c = 0; c < 24000; c++) begin
            gap = (c < 12000) ? 40 : 900;
            bus.h_cnt = 10'(h);
            bus.vga_line_start = (h == 0);
            if (h == 0) act = ($urandom_range(0, 9) < 8);
            bus.vga_vactive = act;
            bus.ppu_pix_valid = 1'b0;
            if (rem == 0) begin
                if ($urandom_range(0, gap) == 0) begin
                    bus.ppu_line_start = 1'b1;
                    rem = SRC;
                end else begin
                    bus.ppu_pix_valid = ($urandom_range(0, 19) == 0);
                end
            end else if ($urandom_range(0, 1999) == 0) begin
                bus.ppu_line_start = 1'b1;
                rem = SRC;
            end else if ($urandom_range(0, 9) != 0) begin
                bus.ppu_pix_valid = 1'b1;
                rem--;
            end
            if ($urandom_range(0, 4999) == 0) bus.frame_sync = 1'b1;
            if ($urandom_range(0, 799) == 0) bus.flag_clr = 1'b1;
            tick();
            h = (h == LINE_LEN - 1) ? 0 : h + 1;
        end
        bus.ppu_pix_valid = 1'b0;

        // Set wins over a simultaneous clear
        bus.frame_sync = 1'b1;
        tick();
        bus.flag_clr = 1'b1;
        tick();
        chk("clr_before_setwin", int'(bus.underrun), 0);
        bus.flag_clr = 1'b1; bus.vga_line_start = 1'b1; bus.vga_vactive = 1'b1; bus.h_cnt = 10'd0;
        tick();
        bus.h_cnt = 10'd1;
        chk("udr_set_wins", int'(bus.underrun), 1);
`ifdef LINE_BUF_STATS_EN
        chk("udr_cnt_set_wins", int'(bus.udr_cnt), 1);
        bus.flag_clr = 1'b1;
        tick();
        chk("udr_cnt_clr", int'(bus.udr_cnt), 0);
        for (int i = 0; i < 300; i++) begin
            bus.vga_line_start = 1'b1; bus.vga_vactive = 1'b1; bus.h_cnt = 10'd0;
            tick();
            bus.h_cnt = 10'd1;
            tick();
        end
        chk("udr_cnt_sat", int'(bus.udr_cnt), 255);
`endif
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
